// File: rtl/mc_mem_pkg.sv
// Shared definitions for the multicycle core's memory responder: state encoding,
// word width and the access-rejection rule.
package mc_mem_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // An access is rejected when the byte address is not word aligned or the
    // word index falls past the end of the array.
    function automatic logic mem_addr_bad(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction
endpackage

// File: rtl/mc_mem_responder_word_ram.sv
// Single-port word RAM: synchronous write, registered read. The read register
// clears to zero whenever no read is issued, so it can drive rdata directly.
import mc_mem_pkg::*;

module word_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata <= '0;
        else       rdata <= re ? mem[addr] : '0;
    end
endmodule

// File: rtl/mc_mem_responder.sv
// Memory responder for the multicycle ARM core: accepts one request, waits
// WAIT_CYCLES, performs the access and pulses ready (with err on rejects).
import mc_mem_pkg::*;

module mc_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy,
    output logic [1:0]        dbg_state
);
    localparam int AW = $clog2(DEPTH_WORDS);

    // Handshake: req is sampled only in IDLE; addr/we/wdata need to be valid
    // on that accept edge only. ready is a one-cycle completion pulse and
    // err/rdata are meaningful only while ready is high.
    state_t            state;
    logic [3:0]        cnt;
    logic [31:0]       req_addr;
    logic              req_we;
    logic [WORD_W-1:0] req_wdata;

    logic [31:0]       acc_addr;
    logic              acc_we;
    logic [WORD_W-1:0] acc_wdata;
    logic              go_resp;
    logic              bad;
    logic              ram_we;
    logic              ram_re;

    // With zero wait states the access happens on the accept edge itself, so
    // the live inputs are used instead of the not-yet-loaded request registers.
    always_comb begin
        acc_addr  = (state == IDLE) ? addr  : req_addr;
        acc_we    = (state == IDLE) ? we    : req_we;
        acc_wdata = (state == IDLE) ? wdata : req_wdata;
        go_resp   = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt == 4'd0));
        bad       = mem_addr_bad(acc_addr, DEPTH_WORDS);
        // Gating with reset lets a reset coincident with RESP entry suppress the write.
        ram_we    = go_resp && acc_we  && !bad && !reset;
        ram_re    = go_resp && !acc_we && !bad && !reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ready     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        req_addr  <= addr;
                        req_we    <= we;
                        req_wdata <= wdata;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                            ready <= 1'b1;
                            err   <= bad;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= bad;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

    word_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_mc_mem_responder.sv
// Bench for mc_mem_responder: one instance with two wait states, one with none,
// both checked against a plain array model of the memory.
module tb_mc_mem_responder;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req2 = 1'b0, we2 = 1'b0;
    logic [31:0] addr2 = '0, wdata2 = '0;
    logic [31:0] rdata2;
    logic        ready2, err2, busy2;
    logic [1:0]  st2;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [31:0] rdata0;
    logic        ready0, err0, busy0;
    logic [1:0]  st0;

    logic [31:0] mem2 [DEPTH];
    logic [31:0] mem0 [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .rdata(rdata2), .ready(ready2), .err(err2), .busy(busy2), .dbg_state(st2)
    );

    mc_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0), .dbg_state(st0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else     begin req2 = r; we2 = w; addr2 = a; wdata2 = d; end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ready0 : ready2;
    endfunction
    function automatic logic bsy(input bit sel);
        return sel ? busy0 : busy2;
    endfunction
    function automatic logic er(input bit sel);
        return sel ? err0 : err2;
    endfunction
    function automatic logic [31:0] rd(input bit sel);
        return sel ? rdata0 : rdata2;
    endfunction

    function automatic logic addr_rejected(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] model_read(input bit sel, input logic [31:0] a);
        int idx;
        idx = int'(a / 4);
        return sel ? mem0[idx] : mem2[idx];
    endfunction

    // One complete access; ready must appear wait_states+1 cycles after the accept edge.
    task automatic access(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d);
        int          lat;
        int          ws;
        bit          seen;
        logic        e;
        logic [31:0] exp_rd;
        ws = sel ? 0 : 2;
        e  = addr_rejected(a);
        exp_rd = (!w && !e) ? model_read(sel, a) : 32'h0;
        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        @(negedge clk);
        drive(sel, 1'b0, 1'($urandom_range(0, 1)), $urandom(), $urandom());
        lat  = 1;
        seen = 0;
        while (!seen && lat <= 20) begin
            if (rdy(sel)) seen = 1;
            else begin
                check("busy_while_waiting", 32'(bsy(sel)), 32'd1);
                @(negedge clk);
                lat++;
            end
        end
        check("ready_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", lat, ws + 1);
            check("err", 32'(er(sel)), 32'(e));
            check("rdata", rd(sel), exp_rd);
            check("busy_in_resp", 32'(bsy(sel)), 32'd1);
            @(negedge clk);
            check("ready_pulse_end", 32'(rdy(sel)), 32'd0);
            check("rdata_cleared", rd(sel), 32'h0);
            check("busy_after", 32'(bsy(sel)), 32'd0);
        end
        if (w && !e) begin
            if (sel) mem0[int'(a / 4)] = d;
            else     mem2[int'(a / 4)] = d;
        end
    endtask

    // Reads with req held high the whole time; completions must be wait_states+2 apart.
    task automatic back_to_back(input bit sel, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2);
        logic [31:0] al [3];
        int k, cyc, last, ws;
        al[0] = a0; al[1] = a1; al[2] = a2;
        ws = sel ? 0 : 2;
        k = 0; cyc = 0; last = -1;
        @(negedge clk);
        drive(sel, 1'b1, 1'b0, al[0], 32'h0);
        while (k < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (rdy(sel)) begin
                check("b2b_err", 32'(er(sel)), 32'd0);
                check("b2b_rdata", rd(sel), model_read(sel, al[k]));
                if (last >= 0) check("b2b_spacing", cyc - last, ws + 2);
                last = cyc;
                k++;
                if (k < 3) drive(sel, 1'b1, 1'b0, al[k], 32'h0);
                else       drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
            end else if (last >= 0 && cyc == last + 1) begin
                check("b2b_not_accepted_in_resp", 32'(bsy(sel)), 32'd0);
            end
        end
        check("b2b_count", k, 3);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 32'($urandom_range(0, DEPTH - 1)) * 4;
            2:       return 32'($urandom_range(0, DEPTH * 4 - 1));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] old;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset: nothing may move.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready2", 32'(ready2), 32'd0);
            check("idle_err2",   32'(err2),   32'd0);
            check("idle_busy2",  32'(busy2),  32'd0);
            check("idle_rdata2", rdata2,      32'h0);
            check("idle_state2", 32'(st2),    32'd0);
            check("idle_ready0", 32'(ready0), 32'd0);
            check("idle_busy0",  32'(busy0),  32'd0);
            check("idle_rdata0", rdata0,      32'h0);
        end

        // Fill both memories so every later read has a known expected value.
        for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom());
        for (int i = 0; i < DEPTH; i++) access(1'b1, 1'b1, 32'(i * 4), $urandom());

        // Store then read back.
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b0, 1'b0, 32'h10, 32'h0);

        back_to_back(1'b0, 32'h0, 32'h4, 32'h8);

        // Rejected accesses.
        access(1'b0, 1'b0, 32'h13, 32'h0);
        access(1'b0, 1'b1, 32'h100, 32'hA5A5A5A5);
        access(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset while a store is waiting: abandoned, memory untouched.
        old = mem2[8];
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("midstore_busy", 32'(busy2), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midstore_reset_busy",  32'(busy2), 32'd0);
        check("midstore_reset_state", 32'(st2),   32'd0);
        check("midstore_reset_ready", 32'(ready2), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midstore_no_ready", 32'(ready2), 32'd0);
        end
        check("midstore_model_unchanged", mem2[8], old);
        access(1'b0, 1'b0, 32'h20, 32'h0);

        // Zero wait states.
        access(1'b1, 1'b1, 32'h24, 32'hCAFEF00D);
        access(1'b1, 1'b0, 32'h24, 32'h0);
        back_to_back(1'b1, 32'h4, 32'hFC, 32'h24);

        // Random traffic on both instances; memory survived the reset pulse.
        for (int i = 0; i < 40; i++)
            access(1'b0, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
        for (int i = 0; i < 20; i++)
            access(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
